// File: rtl/jtkicker_objscan_if.sv
// Draw/busy handshake between the object-table scanner and the line object drawer.
// The scanner presents the attributes of the object it is requesting.
interface jtkicker_objscan_if;
    logic       draw;
    logic       busy;
    logic [7:0] xpos;
    logic [3:0] ysub;
    logic [4:0] pal;
    logic       hflip;
    logic       vflip;
    logic [7:0] code;

    modport master (output draw, xpos, ysub, pal, hflip, vflip, code, input busy);
    modport slave  (input draw, xpos, ysub, pal, hflip, vflip, code, output busy);
endinterface

// File: rtl/jtkicker_objscan.sv
// Walks the object RAM once per line, highest entry first, and hands every
// vertically visible object to the line drawer over the draw/busy handshake.
module jtkicker_objscan #(
    parameter int         OBJMAX    = 24,
    parameter logic [7:0] YOFFSET   = 8'd0,
    parameter logic [7:0] XFLIP_REF = 8'd240
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cen2,
    input  logic        hinit_x,
    input  logic [7:0]  vrender,
    input  logic        flip,
    output logic [6:0]  ram_addr,
    input  logic [7:0]  ram_dout,
    output logic        done,
    jtkicker_objscan_if.master obj
);
    localparam logic [4:0] LAST = 5'(OBJMAX - 1);

    typedef enum logic [2:0] {IDLE, READ, CHECK, REQ, NEXT} state_t;

    state_t     state;
    logic [4:0] entry;
    logic [2:0] rd_cnt;
    logic [7:0] y_r, code_r, attr_r, x_r;
    logic [7:0] dy;
    logic       attr_unused;

    // NOTE: combinational logic assigns every output on every path, so no latch is inferred.
    always_comb begin
        dy = vrender + YOFFSET - y_r;
    end

    assign attr_unused = attr_r[5];

    // NOTE: all state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            entry     <= '0;
            rd_cnt    <= '0;
            ram_addr  <= '0;
            y_r       <= '0;
            code_r    <= '0;
            attr_r    <= '0;
            x_r       <= '0;
            done      <= 1'b0;
            obj.draw  <= 1'b0;
            obj.xpos  <= '0;
            obj.ysub  <= '0;
            obj.pal   <= '0;
            obj.hflip <= 1'b0;
            obj.vflip <= 1'b0;
            obj.code  <= '0;
        end else if (cen2) begin
            // A line start overrides whatever is in flight; an accepted object keeps drawing.
            if (hinit_x) begin
                obj.draw <= 1'b0;
                done     <= 1'b0;
                entry    <= LAST;
                ram_addr <= {LAST, 2'b00};
                rd_cnt   <= '0;
                state    <= READ;
            end else begin
                case (state)
                    IDLE: ;
                    READ: begin
                        // Address runs one cen2 ahead of the captured byte.
                        if (rd_cnt < 3'd3) ram_addr[1:0] <= rd_cnt[1:0] + 2'd1;
                        case (rd_cnt)
                            3'd1:    y_r    <= ram_dout;
                            3'd2:    code_r <= ram_dout;
                            3'd3:    attr_r <= ram_dout;
                            3'd4:    x_r    <= ram_dout;
                            default: ;
                        endcase
                        rd_cnt <= rd_cnt + 3'd1;
                        if (rd_cnt == 3'd4) state <= CHECK;
                    end
                    CHECK: begin
                        if (dy[7:4] == 4'd0) begin
                            obj.xpos  <= flip ? XFLIP_REF - x_r : x_r;
                            obj.ysub  <= dy[3:0];
                            obj.pal   <= attr_r[4:0];
                            obj.hflip <= attr_r[6] ^ flip;
                            obj.vflip <= attr_r[7] ^ flip;
                            obj.code  <= code_r;
                            state     <= REQ;
                        end else begin
                            state <= NEXT;
                        end
                    end
                    REQ: begin
                        if (!obj.draw) begin
                            if (!obj.busy) obj.draw <= 1'b1;
                        end else if (obj.busy) begin
                            obj.draw <= 1'b0;
                            state    <= NEXT;
                        end
                    end
                    NEXT: begin
                        if (entry == 5'd0) begin
                            done  <= 1'b1;
                            state <= IDLE;
                        end else begin
                            entry    <= entry - 5'd1;
                            ram_addr <= {entry - 5'd1, 2'b00};
                            rd_cnt   <= '0;
                            state    <= READ;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_jtkicker_objscan.sv
// Randomised and directed scans of jtkicker_objscan against a table-walk model;
// a monitor pops expected objects from a scoreboard queue on each draw request.
module tb_jtkicker_objscan;
    localparam int         OBJMAX = 24;
    localparam logic [7:0] YOFF   = 8'd0;
    localparam logic [7:0] XREF   = 8'd240;

    typedef struct packed {
        logic [7:0] xpos;
        logic [3:0] ysub;
        logic [4:0] pal;
        logic       hflip;
        logic       vflip;
        logic [7:0] code;
    } obj_t;

    logic       clk = 1'b0, rst = 1'b1, cen2 = 1'b0, hinit_x = 1'b0, flip = 1'b0;
    logic [7:0] vrender = 8'd0;
    logic [6:0] ram_addr;
    logic [7:0] ram_dout;
    logic       done;
    logic [7:0] mem [128];

    jtkicker_objscan_if obj ();

    jtkicker_objscan #(.OBJMAX(OBJMAX), .YOFFSET(YOFF), .XFLIP_REF(XREF)) dut (
        .clk(clk), .rst(rst), .cen2(cen2), .hinit_x(hinit_x), .vrender(vrender),
        .flip(flip), .ram_addr(ram_addr), .ram_dout(ram_dout), .done(done), .obj(obj)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cen2 <= ~cen2;
    always @(posedge clk) if (cen2) ram_dout <= mem[ram_addr];

    // Drawer: accepts a request, stays busy for busy_hold cen2 cycles.
    int   busy_hold = 40;
    logic busy_stuck = 1'b0, drawer_off = 1'b0;
    int   bcnt;
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            obj.busy <= 1'b0;
            bcnt     <= 0;
        end else if (cen2) begin
            if (busy_stuck) begin
                obj.busy <= 1'b1;
                bcnt     <= 1;
            end else if (obj.busy) begin
                bcnt <= bcnt - 1;
                if (bcnt <= 1) obj.busy <= 1'b0;
            end else if (obj.draw && !drawer_off) begin
                obj.busy <= 1'b1;
                bcnt     <= busy_hold;
            end
        end
    end

    int   n_pass = 0, n_total = 0;
    int   n_draws = 0, n_acc = 0;
    int   n_exp, d0, a0;
    obj_t exp_q [$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    function automatic obj_t cur_out();
        return {obj.xpos, obj.ysub, obj.pal, obj.hflip, obj.vflip, obj.code};
    endfunction

    // Monitor: compares every new draw request with the head of the scoreboard.
    initial begin
        logic draw_q, busy_q;
        obj_t held;
        draw_q = 1'b0;
        busy_q = 1'b0;
        held   = '0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (obj.draw && !draw_q) begin
                    n_draws++;
                    check("busy_low_at_draw", 64'(obj.busy), 64'(0));
                    if (exp_q.size() == 0) begin
                        n_total++;
                        $display("FAIL unexpected_draw: got %0h expected no request", cur_out());
                    end else begin
                        check("draw_attr", 64'(cur_out()), 64'(exp_q.pop_front()));
                    end
                    held = cur_out();
                end
                if (!obj.draw && draw_q) check("attr_stable", 64'(cur_out()), 64'(held));
                if (obj.busy && !busy_q) n_acc++;
            end
            draw_q = obj.draw;
            busy_q = obj.busy;
        end
    end

    // Reference: every entry whose line offset lies within the 16-line object, highest first.
    task automatic model_scan(input logic [7:0] vr, input logic fl);
        logic [7:0] dy, a, x;
        obj_t o;
        exp_q.delete();
        for (int e = OBJMAX - 1; e >= 0; e--) begin
            dy = vr + YOFF - mem[7'(e * 4)];
            if (dy < 8'd16) begin
                a       = mem[7'(e * 4 + 2)];
                x       = mem[7'(e * 4 + 3)];
                o.xpos  = fl ? XREF - x : x;
                o.ysub  = dy[3:0];
                o.pal   = a[4:0];
                o.hflip = a[6] ^ fl;
                o.vflip = a[7] ^ fl;
                o.code  = mem[7'(e * 4 + 1)];
                exp_q.push_back(o);
            end
        end
    endtask

    // Returns at a falling edge whose following rising edge carries cen2.
    task automatic cen_step();
        @(negedge clk);
        while (!cen2) @(negedge clk);
    endtask

    task automatic do_hinit(input logic [7:0] vr, input logic fl);
        cen_step();
        vrender = vr;
        flip    = fl;
        model_scan(vr, fl);
        n_exp   = exp_q.size();
        d0      = n_draws;
        a0      = n_acc;
        hinit_x = 1'b1;
        @(posedge clk);
        #1 hinit_x = 1'b0;
    endtask

    task automatic wait_done(input int adj);
        for (int i = 0; i < 8000; i++) begin
            @(negedge clk);
            if (done) break;
        end
        check("done", 64'(done), 64'(1));
        check("queue_empty", 64'(exp_q.size()), 64'(0));
        check("draw_count", 64'(n_draws - d0), 64'(n_exp));
        check("accept_count", 64'(n_acc - a0), 64'(n_draws - d0 + adj));
    endtask

    task automatic wait_draw(input logic level);
        for (int i = 0; i < 4000; i++) begin
            @(negedge clk);
            if (obj.draw == level) break;
        end
        check("draw_wait", 64'(obj.draw), 64'(level));
    endtask

    task automatic fill(input logic [7:0] y);
        for (int e = 0; e < OBJMAX; e++) begin
            mem[7'(e * 4)]     = y;
            mem[7'(e * 4 + 1)] = 8'(e);
            mem[7'(e * 4 + 2)] = 8'h00;
            mem[7'(e * 4 + 3)] = 8'h00;
        end
    endtask

    task automatic set_entry(input int e, input logic [7:0] y, c, a, x);
        mem[7'(e * 4)]     = y;
        mem[7'(e * 4 + 1)] = c;
        mem[7'(e * 4 + 2)] = a;
        mem[7'(e * 4 + 3)] = x;
    endtask

    task automatic check_all_zero(input string name);
        check(name, 64'({obj.draw, done, ram_addr, cur_out()}), 64'(0));
    endtask

    initial begin
        logic [7:0] vr;
        for (int i = 0; i < 128; i++) mem[i] = 8'h00;
        fill(8'h80);
        repeat (4) @(posedge clk);
        @(negedge clk) rst = 1'b0;
        @(negedge clk);
        check_all_zero("reset_state");

        // Nothing visible: full table walk, address order, done.
        do_hinit(8'h10, 1'b0);
        check("addr_b0", 64'(ram_addr), 64'(7'h5C));
        check("done_clear", 64'(done), 64'(0));
        for (int i = 1; i < 4; i++) begin
            cen_step();
            @(posedge clk);
            #1 check("addr_seq", 64'(ram_addr), 64'(7'h5C + 7'(i)));
        end
        wait_done(0);

        // Single hit, normal and flipped screen.
        set_entry(3, 8'h40, 8'h9A, 8'h45, 8'h30);
        do_hinit(8'h47, 1'b0);
        wait_done(0);
        do_hinit(8'h47, 1'b1);
        wait_done(0);

        // Two hits with a slow drawer: order and one accept per request.
        fill(8'h80);
        set_entry(5, 8'h10, 8'h55, 8'h03, 8'h20);
        set_entry(2, 8'h18, 8'h22, 8'h81, 8'h70);
        do_hinit(8'h1A, 1'b0);
        wait_done(0);

        // Vertical wrap hits; y=0 is a live object; y=0xF0 at line 0 misses.
        fill(8'h80);
        set_entry(7, 8'hF8, 8'h77, 8'h12, 8'h08);
        set_entry(0, 8'h00, 8'h11, 8'hC9, 8'hFF);
        do_hinit(8'h02, 1'b1);
        wait_done(0);
        fill(8'h80);
        set_entry(9, 8'hF0, 8'h66, 8'h01, 8'h10);
        do_hinit(8'h00, 1'b0);
        wait_done(0);

        // Randomised tables.
        for (int it = 0; it < 6; it++) begin
            vr        = 8'($urandom);
            busy_hold = int'($urandom_range(2, 12));
            for (int e = 0; e < OBJMAX; e++)
                set_entry(e, vr - 8'($urandom_range(0, 40)), 8'($urandom), 8'($urandom), 8'($urandom));
            do_hinit(vr, 1'($urandom));
            wait_done(0);
        end

        // Restart on the same cen2 the drawer accepts: no retry of the old request.
        busy_hold = 40;
        fill(8'h80);
        set_entry(23, 8'h10, 8'hA5, 8'h1F, 8'h44);
        do_hinit(8'h12, 1'b0);
        wait_draw(1'b1);
        do_hinit(8'h12, 1'b0);
        check("restart_draw", 64'(obj.draw), 64'(0));
        check("restart_done", 64'(done), 64'(0));
        check("restart_addr", 64'(ram_addr), 64'(7'h5C));
        check("restart_busy", 64'(obj.busy), 64'(1));
        wait_done(1);

        // Drawer stuck busy: scan stalls, done stays low until the next line start.
        fill(8'h80);
        set_entry(10, 8'h30, 8'h3C, 8'h0A, 8'h50);
        busy_stuck = 1'b1;
        do_hinit(8'h35, 1'b0);
        repeat (3000) @(negedge clk);
        check("stuck_done", 64'(done), 64'(0));
        check("stuck_draw", 64'(obj.draw), 64'(0));
        cen_step();
        busy_stuck = 1'b0;
        do_hinit(8'h35, 1'b0);
        wait_done(0);

        // Reset while reading the entry after a drawn object.
        busy_hold = 4;
        fill(8'h80);
        set_entry(23, 8'h20, 8'hC3, 8'h5B, 8'h6E);
        do_hinit(8'h25, 1'b1);
        wait_draw(1'b1);
        wait_draw(1'b0);
        for (int i = 0; i < 3; i++) cen_step();
        #2 rst = 1'b1;
        #1 check_all_zero("reset_mid_read");
        repeat (3) @(negedge clk);
        rst = 1'b0;

        // Reset while a request is held: draw drops without a clock edge.
        drawer_off = 1'b1;
        do_hinit(8'h25, 1'b0);
        wait_draw(1'b1);
        #2 rst = 1'b1;
        #1 check("reset_async_draw", 64'(obj.draw), 64'(0));
        repeat (3) @(negedge clk);
        rst        = 1'b0;
        drawer_off = 1'b0;
        repeat (4) @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
